// File: rtl/neuron_setup_tx_if.sv
// Command channel into the neuron tile setup transmitter.
//   cmd_valid : host has a register-write command present
//   cmd_ready : transmitter idle and able to accept the command
//   cmd_reg   : 3-bit target register code
//   cmd_value : value to write, right-aligned, W bits wide
// The master modport is the host side, the slave modport is the transmitter.
interface neuron_setup_tx_if #(
    parameter int W = 32
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_reg;
    logic [W-1:0] cmd_value;

    modport master (
        output cmd_valid,
        output cmd_reg,
        output cmd_value,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_reg,
        input  cmd_value,
        output cmd_ready
    );
endinterface

// File: rtl/neuron_setup_tx.sv
// Host-side transmitter for the neuron tile byte-wide setup protocol.
// Each accepted command is serialised MSB byte first, either as
// SETUP/STROBE/GAP sequences (one setup_sync rising edge per byte) or,
// for code 101, as a burst of one byte per cycle in stream mode.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   cmd            : command channel (slave modport)
//   execute_req    : host request to run the neuron
//   data_out       : data byte to tile ui_in
//   setup_control  : control code to tile uio_in[3:1]
//   setup_sync     : commit strobe to tile uio_in[4]
//   execute        : tile uio_in[0]
//   busy           : transfer in progress
module neuron_setup_tx #(
    parameter int N_STAGES      = 5,
    parameter int STROBE_CYCLES = 1,
    parameter int GAP_CYCLES    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    neuron_setup_tx_if.slave    cmd,
    input  logic                execute_req,
    output logic [7:0]          data_out,
    output logic [2:0]          setup_control,
    output logic                setup_sync,
    output logic                execute,
    output logic                busy
);
    localparam int INPUTS = 1 << N_STAGES;
    localparam int W      = (INPUTS > 8) ? INPUTS : 8;
    localparam int B      = ((INPUTS / 8) > 1) ? (INPUTS / 8) : 1;
    localparam int CMAX   = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int LW     = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, GAP, STREAM
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   shift_reg, shift_next;      // bytes still to send, next one at the top
    logic [LW-1:0]  left_reg, left_next;        // bytes remaining after the current one
    logic [CW-1:0]  cnt_reg, cnt_next;          // cycles remaining in STROBE/GAP
    logic [7:0]     data_reg, data_next;
    logic [2:0]     ctrl_reg, ctrl_next;
    logic           sync_reg, sync_next;
    logic           exec_reg, exec_next;
    logic           busy_reg, busy_next;

    logic           cmd_ready_int;
    logic           accept;
    logic           single_byte;

    assign cmd_ready_int = rst_n & (state_reg == IDLE);
    assign cmd.cmd_ready = cmd_ready_int;
    assign accept        = cmd.cmd_valid & cmd_ready_int;
    assign single_byte   = (cmd.cmd_reg == 3'b010) | (cmd.cmd_reg == 3'b011) |
                           (cmd.cmd_reg == 3'b100) | (cmd.cmd_reg == 3'b110);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            left_reg  <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
            sync_reg  <= 1'b0;
            exec_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            left_reg  <= left_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            ctrl_reg  <= ctrl_next;
            sync_reg  <= sync_next;
            exec_reg  <= exec_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        left_next  = left_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        ctrl_next  = ctrl_reg;
        sync_next  = sync_reg;
        exec_next  = execute_req & (state_reg == IDLE) & ~accept;

        unique case (state_reg)
            IDLE: begin
                data_next = 8'h00;
                ctrl_next = 3'b000;
                sync_next = 1'b0;
                if (accept) begin
                    shift_next = cmd.cmd_value << 8;
                    if (cmd.cmd_reg == 3'b101) begin
                        state_next = STREAM;
                        ctrl_next  = 3'b101;
                        data_next  = cmd.cmd_value[W-1 -: 8];
                        left_next  = LW'(B - 1);
                    end else begin
                        state_next = SETUP;
                        // 111 aliases the input register; 101 must never appear in sync mode
                        ctrl_next  = (cmd.cmd_reg == 3'b111) ? 3'b000 : cmd.cmd_reg;
                        if (single_byte) begin
                            data_next = cmd.cmd_value[7:0];
                            left_next = '0;
                        end else begin
                            data_next = cmd.cmd_value[W-1 -: 8];
                            left_next = LW'(B - 1);
                        end
                    end
                end
            end
            SETUP: begin
                state_next = STROBE;
                sync_next  = 1'b1;
                cnt_next   = CW'(STROBE_CYCLES - 1);
            end
            STROBE: begin
                if (cnt_reg == '0) begin
                    state_next = GAP;
                    sync_next  = 1'b0;
                    cnt_next   = CW'(GAP_CYCLES - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (left_reg == '0) begin
                    state_next = IDLE;
                    data_next  = 8'h00;
                    ctrl_next  = 3'b000;
                end else begin
                    state_next = SETUP;
                    data_next  = shift_reg[W-1 -: 8];
                    shift_next = shift_reg << 8;
                    left_next  = left_reg - 1'b1;
                end
            end
            STREAM: begin
                if (left_reg == '0) begin
                    state_next = IDLE;
                    data_next  = 8'h00;
                    ctrl_next  = 3'b000;
                end else begin
                    data_next  = shift_reg[W-1 -: 8];
                    shift_next = shift_reg << 8;
                    left_next  = left_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                data_next  = 8'h00;
                ctrl_next  = 3'b000;
                sync_next  = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign data_out      = data_reg;
    assign setup_control = ctrl_reg;
    assign setup_sync    = sync_reg;
    assign execute       = exec_reg;
    assign busy          = busy_reg;
endmodule

// File: tb/tb_neuron_setup_tx.sv
module tb_neuron_setup_tx;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: default timing, carries the scoreboarded traffic
    neuron_setup_tx_if #(.W(32)) bus_a ();
    logic       exec_req_a;
    logic [7:0] data_a;
    logic [2:0] ctrl_a;
    logic       sync_a, exec_a, busy_a;

    neuron_setup_tx #(.N_STAGES(5), .STROBE_CYCLES(1), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(bus_a.slave), .execute_req(exec_req_a),
        .data_out(data_a), .setup_control(ctrl_a), .setup_sync(sync_a),
        .execute(exec_a), .busy(busy_a)
    );

    // DUT B: stretched strobe/gap timing for the execute-blocking case
    neuron_setup_tx_if #(.W(32)) bus_b ();
    logic       exec_req_b;
    logic [7:0] data_b;
    logic [2:0] ctrl_b;
    logic       sync_b, exec_b, busy_b;

    neuron_setup_tx #(.N_STAGES(5), .STROBE_CYCLES(2), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(bus_b.slave), .execute_req(exec_req_b),
        .data_out(data_b), .setup_control(ctrl_b), .setup_sync(sync_b),
        .execute(exec_b), .busy(busy_b)
    );

    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q[$];      // {control, data} per committed/streamed byte
    int          strobe_cnt = 0;
    logic [31:0] tile_weights = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected byte per setup_sync rising edge or stream cycle
    logic       prev_sync = 1'b0;
    logic [7:0] prev_data = '0;
    logic [2:0] prev_ctrl = '0;
    always @(negedge clk) begin
        logic [10:0] e;
        if (sync_a && !prev_sync) begin
            strobe_cnt++;
            chk("commit_stable", {21'd0, prev_ctrl, prev_data}, {21'd0, ctrl_a, data_a});
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_commit actual=%h required=none", {ctrl_a, data_a});
            end else begin
                e = exp_q.pop_front();
                chk("commit_byte", {21'd0, ctrl_a, data_a}, {21'd0, e});
                $display("commit ctrl=%b data=%h", ctrl_a, data_a);
            end
            if (ctrl_a == 3'b001) tile_weights = {tile_weights[23:0], data_a};
        end
        if (ctrl_a == 3'b101) begin
            chk("stream_no_sync", {31'd0, sync_a}, 32'd0);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_stream actual=%h required=none", data_a);
            end else begin
                e = exp_q.pop_front();
                chk("stream_byte", {21'd0, ctrl_a, data_a}, {21'd0, e});
                $display("stream data=%h", data_a);
            end
        end
        prev_sync = sync_a;
        prev_data = data_a;
        prev_ctrl = ctrl_a;
    end

    task automatic push_exp(input logic [2:0] r, input logic [31:0] v);
        int n;
        logic [2:0] c;
        logic [7:0] b;
        n = (r == 3'b010 || r == 3'b011 || r == 3'b100 || r == 3'b110) ? 1 : 4;
        c = (r == 3'b111) ? 3'b000 : r;
        for (int k = 0; k < n; k++) begin
            b = (n == 1) ? v[7:0] : v[31 - 8*k -: 8];
            exp_q.push_back({c, b});
        end
    endtask

    // Issue a command on DUT A; returns at the negedge of cycle T+1
    task automatic send(input logic [2:0] r, input logic [31:0] v);
        int g;
        push_exp(r, v);
        @(negedge clk);
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_reg   = r;
        bus_a.cmd_value = v;
        g = 0;
        while (!bus_a.cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!bus_a.cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen, s0;
        logic last;
        logic b_sync[1:5];
        rst_n = 1'b0;
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_reg   = 3'b010;
        bus_a.cmd_value = 32'h55;
        exec_req_a = 1'b0;
        bus_b.cmd_valid = 1'b0;
        bus_b.cmd_reg   = 3'b000;
        bus_b.cmd_value = '0;
        exec_req_b = 1'b0;

        // Reset with a command pending
        repeat (2) begin
            @(negedge clk);
            chk("reset_outs", {18'd0, bus_a.cmd_ready, busy_a, sync_a, exec_a, ctrl_a, data_a}, 32'd0);
            chk("reset_ready_b", {31'd0, bus_b.cmd_ready}, 32'd0);
        end
        rst_n = 1'b1;
        bus_a.cmd_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {30'd0, bus_a.cmd_ready, busy_a}, 32'd2);
        $display("reset done");

        // Threshold write, single byte
        send(3'b010, 32'h05);
        chk("thr_t1", {19'd0, bus_a.cmd_ready, sync_a, ctrl_a, data_a}, {19'd0, 2'b00, 3'b010, 8'h05});
        @(negedge clk);
        chk("thr_t2_sync", {31'd0, sync_a}, 32'd1);
        @(negedge clk);
        chk("thr_t3", {30'd0, sync_a, bus_a.cmd_ready}, 32'd0);
        @(negedge clk);
        chk("thr_t4_ready", {30'd0, bus_a.cmd_ready, busy_a}, 32'd2);
        chk("thr_t4_idle", {21'd0, ctrl_a, data_a}, 32'd0);
        $display("threshold write done");

        // Weights write, four bytes MSB first
        send(3'b001, 32'hDEADBEEF);
        n = 0;
        while (busy_a && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("weights_busy_cycles", n, 32'd12);
        chk("tile_weights", tile_weights, 32'hDEADBEEF);
        $display("weights write done busy=%0d", n);

        // Stream write
        send(3'b101, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            chk("stream_ctrl", {29'd0, ctrl_a}, 32'd5);
            @(negedge clk);
        end
        chk("stream_end", {20'd0, bus_a.cmd_ready, ctrl_a, data_a}, {20'd0, 1'b1, 11'd0});
        $display("stream done");

        // Code 111 goes out as 000
        send(3'b111, 32'h01020304);
        wait_idle();
        $display("input write done");

        // Back-to-back with command change while busy
        push_exp(3'b011, 32'h17F);
        push_exp(3'b110, 32'hA5);
        @(negedge clk);
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_reg   = 3'b011;
        bus_a.cmd_value = 32'h17F;
        @(negedge clk);
        bus_a.cmd_reg   = 3'b110;
        bus_a.cmd_value = 32'hA5;
        chk("b2b_busy", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        wait_idle();
        chk("b2b_gap_idle", {20'd0, sync_a, ctrl_a, data_a}, 32'd0);
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        chk("b2b_second_busy", {31'd0, busy_a}, 32'd1);
        wait_idle();
        $display("back-to-back done");

        // Reset during the second weight strobe
        s0 = strobe_cnt;
        send(3'b001, 32'hA1B2C3D4);
        seen = 0;
        last = 1'b0;
        n = 0;
        while (seen < 2 && n < 40) begin
            if (sync_a && !last) seen++;
            last = sync_a;
            if (seen < 2) begin
                @(negedge clk);
                n++;
            end
        end
        if (n >= 40) chk("strobe_wait_timeout", 32'd1, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outs", {19'd0, bus_a.cmd_ready, busy_a, sync_a, ctrl_a, data_a}, 32'd0);
        @(negedge clk);
        chk("midreset_dropped", exp_q.size(), 32'd2);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready", {31'd0, bus_a.cmd_ready}, 32'd1);
        repeat (8) @(negedge clk);
        chk("midreset_no_strobe", strobe_cnt - s0, 32'd2);
        $display("mid-transfer reset done");

        // execute blocking on DUT B (strobe 2, gap 2)
        exec_req_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("exec_idle_high", {31'd0, exec_b}, 32'd1);
        b_sync[1] = 1'b0; b_sync[2] = 1'b1; b_sync[3] = 1'b1; b_sync[4] = 1'b0; b_sync[5] = 1'b0;
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_reg   = 3'b100;
        bus_b.cmd_value = 32'h3;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            bus_b.cmd_valid = 1'b0;
            chk("exec_blocked", {31'd0, exec_b}, 32'd0);
            chk("b_xfer", {19'd0, bus_b.cmd_ready, sync_b, ctrl_b, data_b},
                {19'd0, 1'b0, b_sync[t], 3'b100, 8'h03});
        end
        @(negedge clk);
        chk("b_ready_t6", {30'd0, bus_b.cmd_ready, exec_b}, 32'd2);
        @(negedge clk);
        chk("exec_resume_t7", {31'd0, exec_b}, 32'd1);
        $display("execute blocking done");

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
